// File: rtl/game_round_ctrl.sv
// game_round_ctrl: guess-the-number round sequencer (button debounce, LFSR secret, comparator handshake, BCD tries).
// Optional macro GAME_TRY_LIMIT_EN: enforce MAX_TRIES (LOSE reachable); otherwise the count saturates at 99.
`default_nettype none

module game_round_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic Clock,
  input  logic Reset,
  input  logic btn_n,
  output logic press
);
  localparam int            CW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic          level_q, level_d;  // accepted level, 1 = released
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  always_comb begin
    sync_d  = {sync_q[0], btn_n};
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == LAST) begin
        level_d = sync_q[1];
        press_d = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;
endmodule

module game_round_ctrl #(
  parameter int          MAX_TRIES       = 10,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Start_button,
  input  logic       Guess_button,
  input  logic [9:0] guess,
  input  logic       cmp_valid,
  input  logic [1:0] cmp_result,
  output logic       cmp_req,
  output logic [9:0] guess_q,
  output logic [3:0] rdm0,
  output logic [3:0] rdm1,
  output logic       neg,
  output logic [3:0] count0,
  output logic [3:0] count1,
  output logic [2:0] game_state,
  output logic       invalid_guess
);
`ifdef GAME_TRY_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif
  localparam logic [3:0] LIM1 = 4'(MAX_TRIES / 10);
  localparam logic [3:0] LIM0 = 4'(MAX_TRIES % 10);

  typedef enum logic [2:0] {S_IDLE, S_PLAY, S_CHECK, S_WIN, S_LOSE} state_t;

  state_t      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [2:0]  game_state_q, game_state_d;
  logic        cmp_req_q, cmp_req_d;
  logic [9:0]  guess_d;
  logic [3:0]  rdm0_q, rdm0_d, rdm1_q, rdm1_d, count0_q, count0_d, count1_q, count1_d;
  logic        neg_q, neg_d, invalid_q, invalid_d;
  logic [3:0]  draw0, draw1, inc0, inc1;
  logic        at_limit, start_pulse, guess_pulse;

  game_round_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
    .Clock(Clock), .Reset(Reset), .btn_n(Start_button), .press(start_pulse)
  );
  game_round_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_guess_db (
    .Clock(Clock), .Reset(Reset), .btn_n(Guess_button), .press(guess_pulse)
  );

  function automatic logic [3:0] fold_digit(input logic [3:0] v);
    fold_digit = (v > 4'd9) ? v - 4'd10 : v;
  endfunction

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    draw0  = fold_digit(lfsr_q[3:0]);
    draw1  = fold_digit(lfsr_q[7:4]);
    // BCD increment that sticks at 99
    if ({count1_q, count0_q} == 8'h99) begin
      inc1 = count1_q;
      inc0 = count0_q;
    end else if (count0_q == 4'd9) begin
      inc1 = count1_q + 4'd1;
      inc0 = 4'd0;
    end else begin
      inc1 = count1_q;
      inc0 = count0_q + 4'd1;
    end
    at_limit = LIMIT_EN && ({inc1, inc0} == {LIM1, LIM0});

    state_d      = state_q;
    game_state_d = game_state_q;
    cmp_req_d    = cmp_req_q;
    guess_d      = guess_q;
    rdm0_d       = rdm0_q;
    rdm1_d       = rdm1_q;
    neg_d        = neg_q;
    count0_d     = count0_q;
    count1_d     = count1_q;
    invalid_d    = 1'b0;

    if (start_pulse) begin
      rdm0_d       = draw0;
      rdm1_d       = draw1;
      neg_d        = lfsr_q[8] & ((draw0 | draw1) != 4'd0);
      count0_d     = 4'd0;
      count1_d     = 4'd0;
      cmp_req_d    = 1'b0;
      state_d      = S_PLAY;
      game_state_d = 3'd1;
    end else begin
      case (state_q)
        S_PLAY: begin
          if (guess_pulse) begin
            if (guess[7:4] <= 4'd9 && guess[3:0] <= 4'd9) begin
              guess_d   = guess;
              cmp_req_d = 1'b1;
              state_d   = S_CHECK;
            end else begin
              invalid_d = 1'b1;
            end
          end
        end
        S_CHECK: begin
          if (cmp_valid && cmp_result != 2'b00) begin
            cmp_req_d = 1'b0;
            count0_d  = inc0;
            count1_d  = inc1;
            if (cmp_result == 2'b11) begin
              state_d      = S_WIN;
              game_state_d = 3'd4;
            end else if (at_limit) begin
              state_d      = S_LOSE;
              game_state_d = 3'd5;
            end else begin
              state_d      = S_PLAY;
              game_state_d = (cmp_result == 2'b01) ? 3'd2 : 3'd3;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q      <= S_IDLE;
      lfsr_q       <= LFSR_SEED;
      game_state_q <= 3'd0;
      cmp_req_q    <= 1'b0;
      guess_q      <= '0;
      rdm0_q       <= '0;
      rdm1_q       <= '0;
      neg_q        <= 1'b0;
      count0_q     <= '0;
      count1_q     <= '0;
      invalid_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      game_state_q <= game_state_d;
      cmp_req_q    <= cmp_req_d;
      guess_q      <= guess_d;
      rdm0_q       <= rdm0_d;
      rdm1_q       <= rdm1_d;
      neg_q        <= neg_d;
      count0_q     <= count0_d;
      count1_q     <= count1_d;
      invalid_q    <= invalid_d;
    end
  end

  assign cmp_req       = cmp_req_q;
  assign rdm0          = rdm0_q;
  assign rdm1          = rdm1_q;
  assign neg           = neg_q;
  assign count0        = count0_q;
  assign count1        = count1_q;
  assign game_state    = game_state_q;
  assign invalid_guess = invalid_q;
endmodule

`default_nettype wire
